// File: rtl/lcd_result_writer_if.sv
// lcd_result_writer_if: request handshake and LCD bus between controller, writer and display.
//   start/idx/value : controller -> writer, one result per request (start sampled while busy=0)
//   busy/done       : writer -> controller, busy during init and writes, done pulses once per write
//   lcd_rs/lcd_rw/lcd_e/lcd_data : writer -> HD44780 character LCD, 8-bit mode, write only
//   modport master  : controller side; modport slave : writer side
interface lcd_result_writer_if;
    logic       start;
    logic [1:0] idx;
    logic [7:0] value;
    logic       busy;
    logic       done;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [7:0] lcd_data;
    modport master (output start, idx, value, input busy, done, lcd_rs, lcd_rw, lcd_e, lcd_data);
    modport slave  (input start, idx, value, output busy, done, lcd_rs, lcd_rw, lcd_e, lcd_data);
endinterface

// File: rtl/lcd_result_writer.sv
// lcd_result_writer: writes one 8-bit convolution result as "Cxy=ddd" to an HD44780 LCD.
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus        : lcd_result_writer_if.slave (start/idx/value in, busy/done and LCD pins out)
//   Runs power-up wait and init commands after reset, then per request converts value to
//   decimal by repeated subtraction and emits one address command plus seven characters.
module lcd_result_writer #(
    parameter int INIT_WAIT = 1500000,
    parameter int E_HIGH    = 50,
    parameter int CMD_WAIT  = 5000,
    parameter int CLR_WAIT  = 200000
) (
    input logic                 clk,
    input logic                 rst_n,
    lcd_result_writer_if.slave  bus
);
    localparam int M1 = INIT_WAIT > CLR_WAIT ? INIT_WAIT : CLR_WAIT;
    localparam int M2 = CMD_WAIT > E_HIGH ? CMD_WAIT : E_HIGH;
    localparam int CW = $clog2((M1 > M2 ? M1 : M2) + 1);
    typedef enum logic [2:0] {PWR_WAIT, IDLE, BCD, SETUP, EHI, HOLD} state_t;
    state_t        state;
    logic          in_init;
    logic [2:0]    bi;
    logic [CW-1:0] cnt;
    logic [1:0]    idx_q;
    logic [7:0]    rem;
    logic [1:0]    hun;
    logic [3:0]    ten;
    logic [2:0]    nbi;
    logic [8:0]    nxt;
    logic          last;
    logic          hold_end;
    assign bus.lcd_rw = 1'b0;
    // Index of the byte loaded at the coming SETUP: first byte unless continuing a sequence
    assign nbi  = state == HOLD ? bi + 3'd1 : 3'd0;
    assign last = in_init ? bi == 3'd3 : bi == 3'd7;
    // The clear command is the only byte needing the long wait
    assign hold_end = cnt == ((bus.lcd_data == 8'h01 && !bus.lcd_rs) ? CW'(CLR_WAIT - 1) : CW'(CMD_WAIT - 1));
    // {rs, data} of the byte to present at the next SETUP
    always_comb begin
        nxt = 9'h000;
        if (in_init)
            case (nbi[1:0])
                2'd0: nxt = 9'h038;
                2'd1: nxt = 9'h00C;
                2'd2: nxt = 9'h006;
                2'd3: nxt = 9'h001;
            endcase
        else
            case (nbi)
                3'd0: nxt = {2'b01, idx_q[1], 2'b00, idx_q[0], 3'b000};
                3'd1: nxt = {1'b1, 8'h43};
                3'd2: nxt = {1'b1, 8'h31 + {7'd0, idx_q[1]}};
                3'd3: nxt = {1'b1, 8'h31 + {7'd0, idx_q[0]}};
                3'd4: nxt = {1'b1, 8'h3D};
                3'd5: nxt = {1'b1, 4'h3, 2'b00, hun};
                3'd6: nxt = {1'b1, 4'h3, ten};
                3'd7: nxt = {1'b1, 4'h3, rem[3:0]};
            endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= PWR_WAIT;
            in_init      <= 1'b1;
            bi           <= '0;
            cnt          <= '0;
            idx_q        <= '0;
            rem          <= '0;
            hun          <= '0;
            ten          <= '0;
            bus.busy     <= 1'b1;
            bus.done     <= 1'b0;
            bus.lcd_rs   <= 1'b0;
            bus.lcd_e    <= 1'b0;
            bus.lcd_data <= 8'h00;
        end else begin
            case (state)
                PWR_WAIT:
                    if (cnt == CW'(INIT_WAIT - 1)) begin
                        cnt                      <= '0;
                        bi                       <= '0;
                        {bus.lcd_rs, bus.lcd_data} <= nxt;
                        state                    <= SETUP;
                    end else
                        cnt <= cnt + 1'b1;
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        idx_q    <= bus.idx;
                        rem      <= bus.value;
                        hun      <= '0;
                        ten      <= '0;
                        in_init  <= 1'b0;
                        bus.busy <= 1'b1;
                        state    <= BCD;
                    end
                end
                BCD:
                    if (rem >= 8'd100) begin
                        rem <= rem - 8'd100;
                        hun <= hun + 2'd1;
                    end else if (rem >= 8'd10) begin
                        rem <= rem - 8'd10;
                        ten <= ten + 4'd1;
                    end else begin
                        bi                       <= '0;
                        {bus.lcd_rs, bus.lcd_data} <= nxt;
                        state                    <= SETUP;
                    end
                SETUP: begin
                    bus.lcd_e <= 1'b1;
                    state     <= EHI;
                end
                EHI:
                    if (cnt == CW'(E_HIGH - 1)) begin
                        cnt       <= '0;
                        bus.lcd_e <= 1'b0;
                        state     <= HOLD;
                    end else
                        cnt <= cnt + 1'b1;
                HOLD:
                    if (!hold_end)
                        cnt <= cnt + 1'b1;
                    else begin
                        cnt <= '0;
                        if (last) begin
                            bus.busy <= 1'b0;
                            bus.done <= !in_init;
                            state    <= IDLE;
                        end else begin
                            bi                       <= bi + 3'd1;
                            {bus.lcd_rs, bus.lcd_data} <= nxt;
                            state                    <= SETUP;
                        end
                    end
                default: state <= PWR_WAIT;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_result_writer.sv
// tb_lcd_result_writer: directed cycle-exact bench for lcd_result_writer with small timing parameters.
module tb_lcd_result_writer;
    localparam int IW  = 20;
    localparam int EH  = 2;
    localparam int CMW = 4;
    localparam int CLW = 8;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad   = 0;
    lcd_result_writer_if bus();
    lcd_result_writer #(.INIT_WAIT(IW), .E_HIGH(EH), .CMD_WAIT(CMW), .CLR_WAIT(CLW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
    always #5 clk = ~clk;
    // Expected output vector: {rw=0, busy, done, e, rs, data}
    function automatic logic [12:0] pk(input logic [3:0] f, input logic [7:0] d);
        return {1'b0, f, d};
    endfunction
    task automatic chk(input string tag, input logic [12:0] exp);
        logic [12:0] got;
        got = {bus.lcd_rw, bus.busy, bus.done, bus.lcd_e, bus.lcd_rs, bus.lcd_data};
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    // Starts observing at SETUP, ends one cycle after the byte's last wait cycle
    task automatic chk_byte(input logic rs, input logic [7:0] d, input int w);
        chk("setup", pk({3'b100, rs}, d));
        repeat (EH) begin
            tick();
            chk("e_high", pk({3'b101, rs}, d));
        end
        repeat (w) begin
            tick();
            chk("hold", pk({3'b100, rs}, d));
        end
        tick();
    endtask
    task automatic chk_init;
        repeat (IW - 1) begin
            tick();
            chk("pwr_wait", pk(4'b1000, 8'h00));
        end
        tick();
        chk_byte(1'b0, 8'h38, CMW);
        chk_byte(1'b0, 8'h0C, CMW);
        chk_byte(1'b0, 8'h06, CMW);
        chk_byte(1'b0, 8'h01, CLW);
        chk("init_idle", pk(4'b0000, 8'h01));
    endtask
    // bcd = cycles spent converting (subtractions plus the final check)
    task automatic write_msg(input logic [1:0] i, input logic [7:0] v, input int bcd,
                             input logic [63:0] msg, input logic poke);
        bus.start = 1'b1;
        bus.idx   = i;
        bus.value = v;
        tick();
        bus.start = poke;
        bus.idx   = poke ? 2'd1 : ~i;
        bus.value = poke ? 8'd7 : ~v;
        repeat (bcd) tick();
        for (int k = 0; k < 8; k++) begin
            chk_byte(k != 0, msg[63-8*k -: 8], CMW);
            bus.start = 1'b0;
        end
        chk("done", pk(4'b0101, msg[7:0]));
    endtask
    initial begin
        bus.start = 1'b0;
        bus.idx   = 2'd0;
        bus.value = 8'd0;
        #1 rst_n = 1'b0;
        #2 chk("reset", pk(4'b1000, 8'h00));
        tick();
        tick();
        rst_n = 1'b1;
        chk_init();
        repeat (3) tick();
        chk("idle", pk(4'b0000, 8'h01));
        write_msg(2'd0, 8'd0, 1, 64'h80_43_31_31_3D_30_30_30, 1'b0);
        tick();
        chk("done_clear", pk(4'b0001, 8'h30));
        write_msg(2'd3, 8'd255, 8, 64'hC8_43_32_32_3D_32_35_35, 1'b1);
        repeat (5) begin
            tick();
            chk("no_queue", pk(4'b0001, 8'h35));
        end
        write_msg(2'd2, 8'd109, 2, 64'hC0_43_32_31_3D_31_30_39, 1'b0);
        write_msg(2'd1, 8'd10, 2, 64'h88_43_31_32_3D_30_31_30, 1'b0);
        tick();
        chk("b2b_end", pk(4'b0001, 8'h30));
        bus.start = 1'b1;
        bus.idx   = 2'd0;
        bus.value = 8'd0;
        tick();
        bus.start = 1'b0;
        tick();
        chk("r_setup", pk(4'b1000, 8'h80));
        repeat (1 + EH + CMW) tick();
        tick();
        chk("r_ehi", pk(4'b1011, 8'h43));
        rst_n = 1'b0;
        #1 chk("async_rst", pk(4'b1000, 8'h00));
        tick();
        rst_n = 1'b1;
        chk_init();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
